hdmi_video_timing: RTL



---
 rtl/hdmi_video_timing.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/hdmi_video_timing.sv
// Raster timing generator with IDLE/RUN/DRAIN sequencing and a one-stage
// registered pixel path that substitutes solid blue when the source starves.
module hdmi_video_timing #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk_low,
    input  logic        reset,
    input  logic        enable,
    input  logic        pix_valid,
    input  logic [23:0] pix_data,
    input  logic        underflow_clr,
    output logic        pix_ready,
    output logic        frame_start,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        underflow
);

    localparam logic [11:0] H_ACT     = 12'(H_ACTIVE);
    localparam logic [11:0] H_S_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_S_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST    = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] V_ACT     = 12'(V_ACTIVE);
    localparam logic [11:0] V_S_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_S_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST    = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    logic [11:0] r_h_cnt;
    logic [11:0] r_v_cnt;
    logic [23:0] r_rgb;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_de;
    logic [11:0] r_x;
    logic [11:0] r_y;
    logic        r_underflow;

    logic w_running;
    logic w_h_last;
    logic w_frame_last;
    logic w_pix_ready;
    logic w_frame_start;
    logic w_hsync_on;
    logic w_vsync_on;
    logic w_starve;

    // Region decode and handshake; ready is gated by reset so nothing is consumed during it.
    always_comb begin
        w_running     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
        w_h_last      = (r_h_cnt == H_LAST);
        w_frame_last  = w_h_last && (r_v_cnt == V_LAST);
        w_pix_ready   = !reset && w_running && (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
        w_frame_start = w_pix_ready && (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
        w_hsync_on    = w_running && (r_h_cnt >= H_S_START) && (r_h_cnt < H_S_END);
        w_vsync_on    = w_running && (r_v_cnt >= V_S_START) && (r_v_cnt < V_S_END);
        w_starve      = w_pix_ready && !pix_valid;
    end

    // Sequencer and raster counters; DRAIN only returns to IDLE on the frame's last slot.
    always_ff @(posedge clk_low) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_h_cnt <= 12'd0;
            r_v_cnt <= 12'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_h_cnt <= 12'd0;
                    r_v_cnt <= 12'd0;
                    r_state <= enable ? ST_RUN : ST_IDLE;
                end
                ST_RUN, ST_DRAIN: begin
                    if (w_h_last) begin
                        r_h_cnt <= 12'd0;
                        r_v_cnt <= (r_v_cnt == V_LAST) ? 12'd0 : r_v_cnt + 12'd1;
                    end else begin
                        r_h_cnt <= r_h_cnt + 12'd1;
                        r_v_cnt <= r_v_cnt;
                    end
                    if (enable) begin
                        r_state <= ST_RUN;
                    end else if ((r_state == ST_DRAIN) && w_frame_last) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_DRAIN;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_h_cnt <= 12'd0;
                    r_v_cnt <= 12'd0;
                end
            endcase
        end
    end

    // Output stage: everything here lags the counters by one cycle.
    always_ff @(posedge clk_low) begin
        if (reset) begin
            r_rgb       <= 24'd0;
            r_de        <= 1'b0;
            r_hsync     <= ~SYNC_POL;
            r_vsync     <= ~SYNC_POL;
            r_x         <= 12'd0;
            r_y         <= 12'd0;
            r_underflow <= 1'b0;
        end else begin
            if (w_pix_ready && pix_valid) begin
                r_rgb <= pix_data;
            end else if (w_starve) begin
                r_rgb <= 24'h0000FF;
            end else begin
                r_rgb <= 24'd0;
            end
            r_de    <= w_pix_ready;
            r_hsync <= w_hsync_on ? SYNC_POL : ~SYNC_POL;
            r_vsync <= w_vsync_on ? SYNC_POL : ~SYNC_POL;
            r_x     <= w_running ? r_h_cnt : 12'd0;
            r_y     <= w_running ? r_v_cnt : 12'd0;
            // A fresh starvation outranks a coincident clear.
            if (w_starve) begin
                r_underflow <= 1'b1;
            end else if (underflow_clr) begin
                r_underflow <= 1'b0;
            end else begin
                r_underflow <= r_underflow;
            end
        end
    end

    assign pix_ready   = w_pix_ready;
    assign frame_start = w_frame_start;
    assign red         = r_rgb[23:16];
    assign green       = r_rgb[15:8];
    assign blue        = r_rgb[7:0];
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign underflow   = r_underflow;

endmodule
